// File: rtl/fetch_addr_gen.sv
// fetch_addr_gen: instruction-fetch address generator with 2 outstanding requests and 2-entry response buffer
//   clk_i, rst_i (async, active-high)
//   req_i fetch enable; branch_i/branch_addr_i redirect pulse and target
//   instr_req_o/instr_addr_o/instr_gnt_i memory request channel (word-aligned address)
//   instr_rvalid_i/instr_rdata_i in-order memory responses
//   valid_o/ready_i/rdata_o/addr_o/misaligned_o buffered fetched words with their fetch addresses
module fetch_addr_gen #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BOOT_ADDR = 32'h0000_0080
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    output logic              instr_req_o,
    output logic [ADDR_W-1:0] instr_addr_o,
    input  logic              instr_gnt_i,
    input  logic              instr_rvalid_i,
    input  logic [ADDR_W-1:0] instr_rdata_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              misaligned_o
);
    logic [ADDR_W-1:0] fetch_addr_q;
    logic [1:0]        cnt, dcnt, occ, live, cnt_n;
    logic [ADDR_W-1:0] af [2];
    logic [ADDR_W-1:0] of_data [2];
    logic [ADDR_W-1:0] of_addr [2];
    logic              af_wr, af_rd, of_wr, of_rd;
    logic              grant, resp, drop, push, pop;

    assign live         = cnt - dcnt;
    // Credit check reserves a buffer slot for every live (non-discarded) request.
    assign instr_req_o  = !rst_i && req_i && !branch_i && (cnt < 2'd2) &&
                          (({1'b0, live} + {1'b0, occ}) < 3'd2);
    assign instr_addr_o = {fetch_addr_q[ADDR_W-1:2], 2'b00};
    assign grant        = instr_req_o && instr_gnt_i;
    // A response with nothing outstanding (e.g. late after reset) is ignored.
    assign resp         = instr_rvalid_i && (cnt != 2'd0);
    assign drop         = resp && (dcnt != 2'd0);
    assign push         = resp && !drop && !branch_i;
    assign pop          = valid_o && ready_i && !branch_i;
    assign cnt_n        = cnt + {1'b0, grant} - {1'b0, resp};
    assign valid_o      = occ != 2'd0;
    assign rdata_o      = of_data[of_rd];
    assign addr_o       = of_addr[of_rd];
    assign misaligned_o = addr_o[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_addr_q <= BOOT_ADDR;
            cnt          <= '0;
            dcnt         <= '0;
            occ          <= '0;
            af_wr        <= 1'b0;
            af_rd        <= 1'b0;
            of_wr        <= 1'b0;
            of_rd        <= 1'b0;
            af           <= '{default: '0};
            of_data      <= '{default: '0};
            of_addr      <= '{default: '0};
        end else begin
            cnt <= cnt_n;
            if (branch_i) begin
                // Everything still in flight belongs to the squashed stream.
                fetch_addr_q <= {branch_addr_i[ADDR_W-1:1], 1'b0};
                dcnt         <= cnt_n;
                occ          <= '0;
                of_wr        <= 1'b0;
                of_rd        <= 1'b0;
            end else begin
                if (grant)
                    fetch_addr_q <= {fetch_addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
                dcnt <= dcnt - {1'b0, drop};
                occ  <= occ + {1'b0, push} - {1'b0, pop};
                if (push)
                    of_wr <= ~of_wr;
                if (pop)
                    of_rd <= ~of_rd;
            end
            if (grant) begin
                af[af_wr] <= fetch_addr_q;
                af_wr     <= ~af_wr;
            end
            if (resp)
                af_rd <= ~af_rd;
            if (push) begin
                of_data[of_wr] <= instr_rdata_i;
                of_addr[of_wr] <= af[af_rd];
            end
        end
    end
endmodule

// File: tb/tb_fetch_addr_gen.sv
// tb_fetch_addr_gen: directed vector table plus hand-written multi-cycle sequences for fetch_addr_gen
module tb_fetch_addr_gen;
    logic        clk = 1'b0;
    logic        rst_i, req_i, branch_i, instr_gnt_i, instr_rvalid_i, ready_i;
    logic [31:0] branch_addr_i, instr_rdata_i;
    logic        instr_req_o, valid_o, misaligned_o;
    logic [31:0] instr_addr_o, rdata_o, addr_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        req, gnt, rv;
        logic [31:0] rdata;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_iaddr;
        logic        exp_valid;
        logic [31:0] exp_addr, exp_data;
    } vec_t;

    typedef struct {
        logic        mis;
        logic [31:0] addr, data;
    } obs_t;

    vec_t        vecs [7];
    logic [31:0] memq [$];
    obs_t        obs [$];
    logic        rv_en;

    fetch_addr_gen dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i),
        .branch_addr_i(branch_addr_i), .instr_req_o(instr_req_o),
        .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
        .valid_o(valid_o), .ready_i(ready_i), .rdata_o(rdata_o),
        .addr_o(addr_o), .misaligned_o(misaligned_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_obs(input int idx, input logic [31:0] exp_addr, input logic [31:0] exp_data);
        if (idx >= obs.size()) begin
            checks++;
            errors++;
            $display("FAIL obs[%0d]: got nothing expected addr %h", idx, exp_addr);
        end else begin
            chk($sformatf("obs[%0d].addr", idx), obs[idx].addr, exp_addr);
            chk($sformatf("obs[%0d].data", idx), obs[idx].data, exp_data);
            chk($sformatf("obs[%0d].mis", idx), {31'd0, obs[idx].mis}, {31'd0, exp_addr[1]});
        end
    endtask

    // Memory model: answers each grant one cycle later when rv_en is set.
    task automatic settle();
        if (rv_en && memq.size() > 0) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = dat(memq.pop_front());
        end else begin
            instr_rvalid_i = 1'b0;
        end
        #1;
        if (instr_req_o && instr_gnt_i)
            memq.push_back(instr_addr_o);
        if (valid_o && ready_i)
            obs.push_back('{misaligned_o, addr_o, rdata_o});
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            settle();
            edge_step();
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
        ready_i = 1'b0; rv_en = 1'b0;
        memq.delete();
        obs.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 1, 0, 32'h0,           1, 1, 32'h80, 0, 32'h0,  32'h0};
        vecs[1] = '{1, 1, 1, dat(32'h80),     1, 1, 32'h84, 0, 32'h0,  32'h0};
        vecs[2] = '{1, 1, 1, dat(32'h84),     1, 0, 32'h88, 1, 32'h80, dat(32'h80)};
        vecs[3] = '{1, 1, 0, 32'h0,           1, 1, 32'h88, 1, 32'h84, dat(32'h84)};
        vecs[4] = '{1, 1, 1, dat(32'h88),     1, 1, 32'h8C, 0, 32'h0,  32'h0};
        vecs[5] = '{1, 1, 1, dat(32'h8C),     1, 0, 32'h90, 1, 32'h88, dat(32'h88)};
        vecs[6] = '{1, 1, 0, 32'h0,           1, 1, 32'h90, 1, 32'h8C, dat(32'h8C)};

        // Reset values, with req_i high to show requests are suppressed.
        do_reset();
        rst_i = 1'b1;
        req_i = 1'b1;
        #1;
        chk("rst.instr_req", {31'd0, instr_req_o}, 32'd0);
        chk("rst.valid", {31'd0, valid_o}, 32'd0);
        chk("rst.rdata", rdata_o, 32'd0);
        chk("rst.addr", addr_o, 32'd0);
        chk("rst.mis", {31'd0, misaligned_o}, 32'd0);
        chk("rst.instr_addr", instr_addr_o, 32'h80);
        edge_step();
        rst_i = 1'b0;

        // Vector table: boot fetch stream with explicit one-cycle responses.
        for (int i = 0; i < 7; i++) begin
            req_i = vecs[i].req; instr_gnt_i = vecs[i].gnt; instr_rvalid_i = vecs[i].rv;
            instr_rdata_i = vecs[i].rdata; ready_i = vecs[i].ready;
            #1;
            chk($sformatf("v%0d.instr_req", i), {31'd0, instr_req_o}, {31'd0, vecs[i].exp_req});
            chk($sformatf("v%0d.instr_addr", i), instr_addr_o, vecs[i].exp_iaddr);
            chk($sformatf("v%0d.valid", i), {31'd0, valid_o}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d.addr", i), addr_o, vecs[i].exp_addr);
                chk($sformatf("v%0d.rdata", i), rdata_o, vecs[i].exp_data);
            end
            edge_step();
        end

        // Branch to a halfword target with two requests outstanding.
        do_reset();
        req_i = 1'b1; instr_gnt_i = 1'b1; ready_i = 1'b1;
        run(2);
        branch_i = 1'b1; branch_addr_i = 32'h0000_1002; rv_en = 1'b1;
        settle();
        chk("br.req_in_branch", {31'd0, instr_req_o}, 32'd0);
        edge_step();
        branch_i = 1'b0;
        settle();
        chk("br.req_after", {31'd0, instr_req_o}, 32'd1);
        chk("br.iaddr_after", instr_addr_o, 32'h0000_1000);
        chk("br.valid_after", {31'd0, valid_o}, 32'd0);
        edge_step();
        run(10);
        chk_obs(0, 32'h0000_1002, dat(32'h0000_1000));
        chk_obs(1, 32'h0000_1004, dat(32'h0000_1004));
        chk_obs(2, 32'h0000_1008, dat(32'h0000_1008));

        // Consumer stall: buffer fills, requests stop, order preserved.
        do_reset();
        req_i = 1'b1; instr_gnt_i = 1'b1; rv_en = 1'b1;
        run(10);
        settle();
        chk("stall.valid", {31'd0, valid_o}, 32'd1);
        chk("stall.req", {31'd0, instr_req_o}, 32'd0);
        chk("stall.head", addr_o, 32'h80);
        edge_step();
        ready_i = 1'b1;
        run(12);
        chk_obs(0, 32'h80, dat(32'h80));
        chk_obs(1, 32'h84, dat(32'h84));
        chk_obs(2, 32'h88, dat(32'h88));
        chk_obs(3, 32'h8C, dat(32'h8C));
        chk_obs(4, 32'h90, dat(32'h90));

        // Grant withheld: request held stable, branch retargets without counting.
        do_reset();
        req_i = 1'b1; ready_i = 1'b1; rv_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("nognt%0d.req", i), {31'd0, instr_req_o}, 32'd1);
            chk($sformatf("nognt%0d.iaddr", i), instr_addr_o, 32'h80);
            edge_step();
        end
        branch_i = 1'b1; branch_addr_i = 32'h0000_2000;
        settle();
        chk("nognt.br_req", {31'd0, instr_req_o}, 32'd0);
        edge_step();
        branch_i = 1'b0;
        settle();
        chk("nognt.req_after", {31'd0, instr_req_o}, 32'd1);
        chk("nognt.iaddr_after", instr_addr_o, 32'h0000_2000);
        edge_step();
        instr_gnt_i = 1'b1;
        run(10);
        chk_obs(0, 32'h0000_2000, dat(32'h0000_2000));
        chk_obs(1, 32'h0000_2004, dat(32'h0000_2004));

        // Address wrap at the top of the space.
        do_reset();
        req_i = 1'b1; instr_gnt_i = 1'b1; ready_i = 1'b1; rv_en = 1'b1;
        branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFF8;
        settle();
        edge_step();
        branch_i = 1'b0;
        run(10);
        chk_obs(0, 32'hFFFF_FFF8, dat(32'hFFFF_FFF8));
        chk_obs(1, 32'hFFFF_FFFC, dat(32'hFFFF_FFFC));
        chk_obs(2, 32'h0000_0000, dat(32'h0000_0000));

        // Reset mid-operation with data buffered and a request outstanding.
        do_reset();
        req_i = 1'b1; instr_gnt_i = 1'b1;
        run(2);
        rv_en = 1'b1;
        run(1);
        rv_en = 1'b0;
        settle();
        chk("mid.valid_before", {31'd0, valid_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        chk("mid.valid_rst", {31'd0, valid_o}, 32'd0);
        chk("mid.req_rst", {31'd0, instr_req_o}, 32'd0);
        edge_step();
        rst_i = 1'b0;
        obs.delete();
        ready_i = 1'b1; rv_en = 1'b1;
        run(8);
        chk_obs(0, 32'h80, dat(32'h80));
        chk_obs(1, 32'h84, dat(32'h84));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
